aes_block_encrypt_iter: RTL
===========================

// Module: aes_block_encrypt_iter
// PURPOSE
//  Iterative (folded) AES encryption core with ready/valid handshakes on both sides.
//  Executes UNROLL rounds per clock over one round-state register instead of a fully
//  unrolled pipe; trades throughput for roughly Nr/UNROLL-times less round logic.
//  Sits between the key-expansion block and the mode/stream wrapper (CTR/ECB front end).
// PARAMETERS
//  KEYLEN  128  key length in bits: 128/192/256; Nr = KEYLEN/32+6 (10/12/14)
//  UNROLL  1    round slots evaluated per cycle; legal 1 or 2 (Nr % UNROLL == 0, elaboration assert)
//  TAG_W   8    width of sideband tag carried unchanged from input to output
// PORTS
//  clk           in   1            clock
//  rst           in   1            asynchronous reset, active-high
//  in_valid      in   1            plaintext block offered
//  in_ready      out  1            core can accept a block this cycle
//  plaintext     in   [3:0][3:0][7:0]  block, FIPS-197 byte order (byte 0 in [127:120])
//  in_tag        in   TAG_W        sideband tag, captured with plaintext
//  expanded_key  in   [Nr:0][127:0]  round keys 0..Nr, same byte order as plaintext
//  out_valid     out  1            ciphertext valid, held until accepted
//  out_ready     in   1            downstream accepts ciphertext
//  ciphertext    out  [3:0][3:0][7:0]  result block
//  out_tag       out  TAG_W        tag of the block on ciphertext
//  busy          out  1            high in RUN or DONE
// BEHAVIOUR
//  Reset: FSM=IDLE, round counter rnd=0, state/ciphertext=0, out_tag=0, out_valid=0, busy=0;
//   in_ready follows from FSM (1 in IDLE). Reset mid-block discards the block; no output.
//  FSM states: IDLE, RUN, DONE.
//  in_ready = (FSM==IDLE) | (FSM==DONE & out_ready). Accept = in_valid & in_ready.
//  Accept edge: state <= plaintext ^ key[0]; tag_q <= in_tag; rnd <= 1; FSM -> RUN.
//  RUN, each cycle: slot j (0..UNROLL-1) applies round rnd+j with key[rnd+j]; slot is a
//   standard round (SubBytes,ShiftRows,MixColumns,ARK) if rnd+j<Nr, reduced round
//   (no MixColumns) if rnd+j==Nr. state <= slot[UNROLL-1] output; rnd <= rnd+UNROLL.
//   When rnd+UNROLL-1 == Nr: FSM -> DONE instead of staying in RUN.
//  DONE: out_valid=1, ciphertext=state, out_tag=tag_q, all stable while out_ready=0.
//   out_ready=1: handshake completes; if in_valid same cycle, new block is loaded
//   (back-to-back, FSM -> RUN), else FSM -> IDLE.
//  Latency: out_valid rises Nr/UNROLL cycles after the accept edge (10 for KEYLEN=128,U=1;
//   5 for U=2). Peak throughput: one block per Nr/UNROLL+1 cycles.
//  expanded_key is not captured: must stay stable from accept through the output handshake;
//   a change while busy gives undefined ciphertext (bench checks no X on control only).
//  in_valid while RUN, or while DONE with out_ready=0: ignored (in_ready=0), no loss of held data.
//  rnd width = $clog2(Nr+2); never exceeds Nr+1 before wrapping to the next load.
//  Outputs are registered; no combinational in_valid->out_valid path.
//   in_ready depends combinationally on out_ready (DONE state only).
// STRUCTURE
//  aes_pkg: typedef aes_block_t ([3:0][3:0][7:0]); function aes_nr(keylen);
//   typedef enum {IDLE,RUN,DONE} aes_iter_state_e.
//  Sub-module aes_round_slot: wraps existing standard and reduced round modules and
//   selects via input 'last'. Instantiated UNROLL times in a generate loop, chained.
//  Round-key mux: key[rnd+j] index is combinational from the counter; block_partition per slot.
// TESTING
//  1 KEYLEN=128,U=1: key 000102..0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept.
//  2 KEYLEN=192 and 256, U=2, same pt: keys 00..17 / 00..1f -> dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089; latency 6 / 7 cycles.
//  3 Backpressure: hold out_ready=0 for 20 cycles in DONE -> ciphertext/out_tag stable, in_ready=0, extra in_valid ignored.
//  4 Back-to-back: in_valid held high, out_ready=1, tags 0x01,0x02,0x03 -> three correct blocks in order, one every Nr/U+1 cycles.
//  5 Reset asserted async at RUN cycle 4 -> out_valid=0, in_ready=1 immediately; next block encrypts correctly.
//  6 Random pt/keys/ready patterns vs C reference model, 10k blocks per KEYLEN/UNROLL combo -> zero mismatches, tags preserved.

Source files
------------

// File: rtl/aes_block_encrypt_iter_pkg.sv
// Shared types and GF(2^8) round primitives for the folded AES encryption core.
// A block is 16 bytes with byte 0 at [127:120], in column-major FIPS-197 order.
package aes_block_encrypt_iter_pkg;

   typedef logic [3:0][3:0][7:0] aes_block_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } aes_iter_state_e;

   function automatic int aes_nr(input int keylen);
      return keylen / 32 + 6;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse computed as x^254 (product of x^2 .. x^128), which also maps 0 to 0
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox(s[8*k +: 8]);
      return r;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-8*(4*c+0) -: 8];
         a1 = s[127-8*(4*c+1) -: 8];
         a2 = s[127-8*(4*c+2) -: 8];
         a3 = s[127-8*(4*c+3) -: 8];
         r[127-8*(4*c+0) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_block_encrypt_iter_round_slot.sv
// One AES round slot: standard round, or the final round without MixColumns when i_last.
// Purely combinational; the top chains UNROLL of these per clock.
module aes_block_encrypt_iter_round_slot
   import aes_block_encrypt_iter_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_key,
   input  logic         i_last,
   output logic [127:0] o_state
);

   logic [127:0] w_sr;
   logic [127:0] w_mc;

   assign w_sr    = shift_rows(sub_bytes(i_state));
   assign w_mc    = mix_columns(w_sr);
   assign o_state = (i_last ? w_sr : w_mc) ^ i_key;

endmodule

// File: rtl/aes_block_encrypt_iter.sv
// Folded AES encryption core: UNROLL rounds per clock over one state register,
// ready/valid on both sides, sideband tag carried with the block.
//
//  state | meaning
//  IDLE  | empty, in_ready=1
//  RUN   | rounds in flight, rnd = next round index
//  DONE  | ciphertext held on outputs until out_ready
module aes_block_encrypt_iter
   import aes_block_encrypt_iter_pkg::*;
#(
   parameter int KEYLEN = 128,
   parameter int UNROLL = 1,
   parameter int TAG_W  = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [3:0][3:0][7:0]             plaintext,
   input  logic [TAG_W-1:0]                 in_tag,
   input  logic [aes_nr(KEYLEN):0][127:0]   expanded_key,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [3:0][3:0][7:0]             ciphertext,
   output logic [TAG_W-1:0]                 out_tag,
   output logic                             busy
);

   localparam int NR = aes_nr(KEYLEN);
   localparam int RW = $clog2(NR + 2);
   localparam int KW = RW + 1;

   if (!((KEYLEN == 128 || KEYLEN == 192 || KEYLEN == 256) &&
         (UNROLL == 1 || UNROLL == 2) && (NR % UNROLL == 0))) begin : g_bad_cfg
      $error("aes_block_encrypt_iter: unsupported KEYLEN/UNROLL combination");
   end

   aes_iter_state_e r_fsm;
   aes_iter_state_e w_fsm_nxt;
   logic [RW-1:0]   r_rnd;
   aes_block_t      r_state;
   logic [TAG_W-1:0] r_tag;
   logic            w_in_ready;
   logic            w_accept;
   logic            w_rnd_last;
   logic [127:0]    w_slot_out;

   // Key index per slot is decoded from the counter; out-of-range indices (rnd past Nr
   // while idle) select zero so the mux never reads beyond the key array.
   for (genvar j = 0; j < UNROLL; j++) begin : g_slot
      logic [KW-1:0] w_kidx;
      logic [127:0]  w_key;
      logic [127:0]  w_in;
      logic [127:0]  w_out;

      assign w_kidx = {1'b0, r_rnd} + KW'(j);

      always_comb begin
         w_key = '0;
         for (int k = 0; k <= NR; k++)
            if (w_kidx == KW'(k)) w_key = expanded_key[k];
      end

      if (j == 0) begin : g_head
         assign w_in = r_state;
      end else begin : g_link
         assign w_in = g_slot[j-1].w_out;
      end

      aes_block_encrypt_iter_round_slot u_slot (
         .i_state (w_in),
         .i_key   (w_key),
         .i_last  (w_kidx == KW'(NR)),
         .o_state (w_out)
      );
   end

   assign w_slot_out = g_slot[UNROLL-1].w_out;

   assign w_in_ready = (r_fsm == IDLE) || ((r_fsm == DONE) && out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_rnd_last = (({1'b0, r_rnd} + KW'(UNROLL - 1)) == KW'(NR));

   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         IDLE:    if (w_accept) w_fsm_nxt = RUN;
         RUN:     if (w_rnd_last) w_fsm_nxt = DONE;
         DONE:    if (out_ready) w_fsm_nxt = w_accept ? RUN : IDLE;
         default: w_fsm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_fsm <= IDLE;
      else     r_fsm <= w_fsm_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= '0;
         r_tag   <= '0;
         r_rnd   <= '0;
      end else if (w_accept) begin
         r_state <= plaintext ^ expanded_key[0];
         r_tag   <= in_tag;
         r_rnd   <= RW'(1);
      end else if (r_fsm == RUN) begin
         r_state <= w_slot_out;
         r_rnd   <= r_rnd + RW'(UNROLL);
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = (r_fsm == DONE);
   assign busy       = (r_fsm != IDLE);
   assign ciphertext = r_state;
   assign out_tag    = r_tag;

endmodule
